// File: rtl/tlb_lookup_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : paging_pkg
//  Purpose  : Shared types and constants for the TLB lookup unit: TLB entry
//             layout, page geometry, PTE field positions and the lookup FSM
//             state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package paging_pkg;

   localparam int PAGE_OFFSET_W   = 12;
   localparam int VPN_W           = 32 - PAGE_OFFSET_W;
   localparam int PTE_PRESENT_BIT = 0;

   // Tag field is sized for the smallest possible index (a single set) so the
   // entry layout does not depend on the SETS parameter; unused upper bits
   // are simply stored as zero.
   typedef struct packed {
      logic             valid;
      logic [VPN_W-1:0] tag;
      logic [VPN_W-1:0] frame;
   } tlb_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_WALK   = 2'd2,
      ST_WAIT   = 2'd3
   } tlb_state_t;

   function automatic logic [31:0] make_phys(input logic [VPN_W-1:0] frame,
                                             input logic [31:0]      lin);
      return {frame, lin[PAGE_OFFSET_W-1:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_lookup_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_lookup_unit_if
//  Purpose  : Bundles the translation request/response signals and the
//             page-walk request/response signals of the TLB.
//  Ports    : slave  - TLB side (receives requests, drives results and walks)
//             master - requester / paging-unit side
//  Revision : 1.0  initial release
// ============================================================================
interface tlb_lookup_unit_if;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_linear_address;
   logic        i_flush;
   logic [31:0] o_physical_address;
   logic        o_hit;
   logic        o_fault;
   logic        o_walk_valid;
   logic [31:0] o_walk_address;
   logic        i_walk_ready;
   logic [31:0] i_walk_pte;

   modport slave (
      input  i_valid, i_linear_address, i_flush, i_walk_ready, i_walk_pte,
      output o_ready, o_physical_address, o_hit, o_fault,
             o_walk_valid, o_walk_address
   );

   modport master (
      output i_valid, i_linear_address, i_flush, i_walk_ready, i_walk_pte,
      input  o_ready, o_physical_address, o_hit, o_fault,
             o_walk_valid, o_walk_address
   );
endinterface
`default_nettype wire

// File: rtl/tlb_lookup_unit_victim_select.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_victim_select
//  Purpose  : Picks the way to overwrite on a fill: the lowest-index invalid
//             way of the set, or the set's round-robin pointer when full.
//  Ports    : i_valid_vec - valid bit of each way in the indexed set
//             i_rr_ptr    - round-robin pointer of the indexed set
//             o_victim    - selected way index
//  Revision : 1.0  initial release
// ============================================================================
module tlb_victim_select #(
   parameter int WAYS  = 4,
   parameter int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-1:0]  i_valid_vec,
   input  logic [WAY_W-1:0] i_rr_ptr,
   output logic [WAY_W-1:0] o_victim
);

   // Scan from the top down so the last assignment wins with the lowest
   // invalid index.
   always_comb begin
      o_victim = i_rr_ptr;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!i_valid_vec[w]) begin
            o_victim = WAY_W'(w);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/tlb_lookup_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_lookup_unit
//  Purpose  : Set-associative TLB in front of the paging unit. Hits answer in
//             the second cycle after acceptance; misses issue a single walk
//             request, optionally fill the returned PTE, then answer.
//  Ports    : clock, reset - system clock, async active-high reset
//             bus          - request/response and walk signals (slave side)
//  Revision : 1.0  initial release
// ============================================================================
module tlb_lookup_unit
   import paging_pkg::*;
#(
   parameter int SETS = 8,
   parameter int WAYS = 4
) (
   input  logic              clock,
   input  logic              reset,
   tlb_lookup_unit_if.slave  bus
);

   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);

   tlb_state_t        state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic              ready_q, ready_d;
   logic              hit_q, hit_d;
   logic              fault_q, fault_d;
   logic [31:0]       phys_q, phys_d;
   logic              walk_valid_q, walk_valid_d;
   logic [31:0]       walk_addr_q, walk_addr_d;
   tlb_entry_t        tlb_q [SETS][WAYS];
   tlb_entry_t        tlb_d [SETS][WAYS];
   logic [WAY_W-1:0]  rr_q [SETS];
   logic [WAY_W-1:0]  rr_d [SETS];

   logic [IDX_W-1:0]  w_set;
   logic [VPN_W-1:0]  w_tag;
   logic [WAYS-1:0]   w_hit_vec;
   logic [WAYS-1:0]   w_valid_vec;
   logic [VPN_W-1:0]  w_hit_frame;
   logic [WAY_W-1:0]  w_victim;
   logic              w_unused_pte_bits;

   assign w_set = addr_q[PAGE_OFFSET_W +: IDX_W];
   assign w_tag = VPN_W'(addr_q[31:PAGE_OFFSET_W+IDX_W]);
   assign w_unused_pte_bits = ^bus.i_walk_pte[PAGE_OFFSET_W-1:PTE_PRESENT_BIT+1];

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      assign w_valid_vec[w] = tlb_q[w_set][w].valid;
      assign w_hit_vec[w]   = tlb_q[w_set][w].valid && (tlb_q[w_set][w].tag == w_tag);
   end

   // At most one way can match, so an OR-style mux is sufficient.
   always_comb begin
      w_hit_frame = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (w_hit_vec[w]) begin
            w_hit_frame = tlb_q[w_set][w].frame;
         end
      end
   end

   tlb_victim_select #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_victim (
      .i_valid_vec (w_valid_vec),
      .i_rr_ptr    (rr_q[w_set]),
      .o_victim    (w_victim)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      ready_d      = ready_q;
      hit_d        = hit_q;
      fault_d      = fault_q;
      phys_d       = phys_q;
      walk_valid_d = walk_valid_q;
      walk_addr_d  = walk_addr_q;
      tlb_d        = tlb_q;
      rr_d         = rr_q;

      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b0;
            hit_d   = 1'b0;
            fault_d = 1'b0;
            if (bus.i_valid) begin
               addr_d  = bus.i_linear_address;
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            // A flush in this cycle invalidates the entry we would hit on,
            // so take the walk path instead.
            if ((|w_hit_vec) && !bus.i_flush) begin
               ready_d = 1'b1;
               hit_d   = 1'b1;
               phys_d  = make_phys(w_hit_frame, addr_q);
               state_d = ST_IDLE;
            end else begin
               walk_valid_d = 1'b1;
               walk_addr_d  = addr_q;
               state_d      = ST_WALK;
            end
         end
         ST_WALK: begin
            walk_valid_d = 1'b0;
            state_d      = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.i_walk_ready) begin
               ready_d = 1'b1;
               hit_d   = 1'b0;
               phys_d  = make_phys(bus.i_walk_pte[31:PAGE_OFFSET_W], addr_q);
               fault_d = ~bus.i_walk_pte[PTE_PRESENT_BIT];
               state_d = ST_IDLE;
               if (bus.i_walk_pte[PTE_PRESENT_BIT] && !bus.i_flush) begin
                  tlb_d[w_set][w_victim].valid = 1'b1;
                  tlb_d[w_set][w_victim].tag   = w_tag;
                  tlb_d[w_set][w_victim].frame = bus.i_walk_pte[31:PAGE_OFFSET_W];
                  // Pointer only advances when it actually chose the victim.
                  if (&w_valid_vec) begin
                     rr_d[w_set] = rr_q[w_set] + 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (bus.i_flush) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               tlb_d[s][w].valid = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         ready_q      <= 1'b0;
         hit_q        <= 1'b0;
         fault_q      <= 1'b0;
         phys_q       <= '0;
         walk_valid_q <= 1'b0;
         walk_addr_q  <= '0;
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tlb_q[s][w] <= '0;
            end
         end
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         ready_q      <= ready_d;
         hit_q        <= hit_d;
         fault_q      <= fault_d;
         phys_q       <= phys_d;
         walk_valid_q <= walk_valid_d;
         walk_addr_q  <= walk_addr_d;
         tlb_q        <= tlb_d;
         rr_q         <= rr_d;
      end
   end

   assign bus.o_ready            = ready_q;
   assign bus.o_hit              = hit_q;
   assign bus.o_fault            = fault_q;
   assign bus.o_physical_address = phys_q;
   assign bus.o_walk_valid       = walk_valid_q;
   assign bus.o_walk_address     = walk_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_tlb_lookup_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlb_lookup_unit
//  Purpose  : Self-checking bench for tlb_lookup_unit: a table of directed
//             accesses with hand-computed results, followed by flush and
//             reset corner-case sequences.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_tlb_lookup_unit;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   tlb_lookup_unit_if bus_if ();

   tlb_lookup_unit #(
      .SETS (8),
      .WAYS (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   typedef struct {
      logic [31:0] lin;
      logic [31:0] pte;
      logic        exp_walk;
      logic [31:0] exp_phys;
      logic        exp_hit;
      logic        exp_fault;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // One complete translation: request, answer any walk with pte, check result.
   task automatic run_access(input string tag, input logic [31:0] lin, input logic [31:0] pte,
                             input logic exp_walk, input logic [31:0] exp_phys,
                             input logic exp_hit, input logic exp_fault,
                             input bit flush_lookup, input bit flush_fill);
      int  lat = 0;
      int  pulses = 0;
      int  wcnt = 0;
      bit  responded = 0;
      bit  done = 0;
      logic [31:0] phys = '0;
      logic hit = 0, fault = 0;
      bus_if.i_valid          = 1'b1;
      bus_if.i_linear_address = lin;
      while (!done && lat < 40) begin
         @(negedge clock);
         lat++;
         bus_if.i_flush      = 1'b0;
         bus_if.i_walk_ready = 1'b0;
         if (bus_if.o_walk_valid) begin
            pulses++;
            check({tag, " walk_addr"}, bus_if.o_walk_address, lin);
         end
         if (bus_if.o_ready) begin
            phys  = bus_if.o_physical_address;
            hit   = bus_if.o_hit;
            fault = bus_if.o_fault;
            done  = 1;
            bus_if.i_valid = 1'b0;
         end else begin
            if (flush_lookup && lat == 1) bus_if.i_flush = 1'b1;
            if (pulses > 0 && !responded) begin
               wcnt++;
               if (wcnt == 2) begin
                  bus_if.i_walk_ready = 1'b1;
                  bus_if.i_walk_pte   = pte;
                  bus_if.i_flush      = flush_fill;
                  responded           = 1;
               end
            end
         end
      end
      bus_if.i_valid = 1'b0;
      check({tag, " ready_seen"}, 32'(done), 32'd1);
      check({tag, " walk_pulses"}, 32'(pulses), exp_walk ? 32'd1 : 32'd0);
      check({tag, " phys"}, phys, exp_phys);
      check({tag, " hit"}, 32'(hit), 32'(exp_hit));
      check({tag, " fault"}, 32'(fault), 32'(exp_fault));
      if (!exp_walk) check({tag, " hit_latency"}, 32'(lat), 32'd2);
      @(negedge clock);
      check({tag, " ready_pulse"}, 32'(bus_if.o_ready), 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " ready"}, 32'(bus_if.o_ready), 32'd0);
      check({tag, " hit"}, 32'(bus_if.o_hit), 32'd0);
      check({tag, " fault"}, 32'(bus_if.o_fault), 32'd0);
      check({tag, " walk_valid"}, 32'(bus_if.o_walk_valid), 32'd0);
      check({tag, " phys"}, bus_if.o_physical_address, 32'd0);
      check({tag, " walk_addr"}, bus_if.o_walk_address, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int guard;
      //          lin            pte            walk phys           hit fault
      vecs[0]  = '{32'h0040_1ABC, 32'h0012_3001, 1, 32'h0012_3ABC, 0, 0};
      vecs[1]  = '{32'h0040_1FFF, 32'h0000_0000, 0, 32'h0012_3FFF, 1, 0};
      vecs[2]  = '{32'h0000_0123, 32'h000A_0001, 1, 32'h000A_0123, 0, 0};
      vecs[3]  = '{32'h0000_8456, 32'h000B_0001, 1, 32'h000B_0456, 0, 0};
      vecs[4]  = '{32'h0001_0789, 32'h000C_0001, 1, 32'h000C_0789, 0, 0};
      vecs[5]  = '{32'h0001_8ABC, 32'h000D_0001, 1, 32'h000D_0ABC, 0, 0};
      vecs[6]  = '{32'h0002_0DEF, 32'h000E_0001, 1, 32'h000E_0DEF, 0, 0}; // evicts way0
      vecs[7]  = '{32'h0000_8000, 32'h0000_0000, 0, 32'h000B_0000, 1, 0};
      vecs[8]  = '{32'h0000_0FFF, 32'h000F_0001, 1, 32'h000F_0FFF, 0, 0}; // evicts way1
      vecs[9]  = '{32'h0001_0000, 32'h0000_0000, 0, 32'h000C_0000, 1, 0};
      vecs[10] = '{32'h0000_8000, 32'h000B_0001, 1, 32'h000B_0000, 0, 0}; // evicts way2
      vecs[11] = '{32'h0002_0000, 32'h0000_0000, 0, 32'h000E_0000, 1, 0};
      vecs[12] = '{32'h0050_0123, 32'h0000_0000, 1, 32'h0000_0123, 0, 1};
      vecs[13] = '{32'h0050_0123, 32'h0000_0000, 1, 32'h0000_0123, 0, 1};
      vecs[14] = '{32'h0040_1000, 32'h0000_0000, 0, 32'h0012_3000, 1, 0};

      reset                   = 1'b1;
      bus_if.i_valid          = 1'b0;
      bus_if.i_linear_address = '0;
      bus_if.i_flush          = 1'b0;
      bus_if.i_walk_ready     = 1'b0;
      bus_if.i_walk_pte       = '0;
      repeat (3) @(negedge clock);
      check_outputs_zero("reset");
      reset = 1'b0;
      @(negedge clock);
      check("post_reset ready", 32'(bus_if.o_ready), 32'd0);

      for (int i = 0; i < NVEC; i++) begin
         run_access($sformatf("v%0d", i), vecs[i].lin, vecs[i].pte, vecs[i].exp_walk,
                    vecs[i].exp_phys, vecs[i].exp_hit, vecs[i].exp_fault, 0, 0);
      end

      // Flush while idle, then the cached page must walk again.
      bus_if.i_flush = 1'b1;
      @(negedge clock);
      bus_if.i_flush = 1'b0;
      run_access("flush_idle", 32'h0040_1ABC, 32'h0012_3001, 1, 32'h0012_3ABC, 0, 0, 0, 0);

      // Flush during the lookup cycle of a cached page forces the walk path.
      run_access("flush_lookup", 32'h0040_1ABC, 32'h0012_3001, 1, 32'h0012_3ABC, 0, 0, 1, 0);
      run_access("refill_hit", 32'h0040_1234, 32'h0000_0000, 0, 32'h0012_3234, 1, 0, 0, 0);

      // Flush coincident with the fill: response still delivered, nothing cached.
      run_access("flush_fill", 32'h0060_0000, 32'h0033_3001, 1, 32'h0033_3000, 0, 0, 0, 1);
      run_access("after_flush_fill", 32'h0060_0000, 32'h0033_3001, 1, 32'h0033_3000, 0, 0, 0, 0);
      run_access("cached_hit", 32'h0060_0FFF, 32'h0000_0000, 0, 32'h0033_3FFF, 1, 0, 0, 0);

      // Reset while waiting for the walk; a late walk response must be ignored.
      bus_if.i_valid          = 1'b1;
      bus_if.i_linear_address = 32'h0070_0000;
      guard = 0;
      do begin
         @(negedge clock);
         guard++;
      end while (!bus_if.o_walk_valid && guard < 20);
      check("rst_wait walk_seen", 32'(bus_if.o_walk_valid), 32'd1);
      repeat (2) @(negedge clock);
      reset          = 1'b1;
      bus_if.i_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      bus_if.i_walk_ready = 1'b1;
      bus_if.i_walk_pte   = 32'h0044_4001;
      @(negedge clock);
      bus_if.i_walk_ready = 1'b0;
      check_outputs_zero("rst_wait a");
      @(negedge clock);
      check_outputs_zero("rst_wait b");

      run_access("rst_next_walk", 32'h0070_0000, 32'h0044_4001, 1, 32'h0044_4000, 0, 0, 0, 0);
      run_access("rst_cleared", 32'h0060_0FFF, 32'h0033_3001, 1, 32'h0033_3FFF, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
